// File: rtl/pixel_addr_gen.sv
// Address generator for a 2x2 sliding-window convolution: scans window origins in raster
// order, issues the four tap read addresses per window and sequential output write addresses.
module pixel_addr_gen #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_clr_i,
  input  logic [AW-1:0] in_base_i,
  input  logic [AW-1:0] out_base_i,
  input  logic          pixel_cnt_en_i,
  input  logic          addr_cal_en_i,
  input  logic          read_i,
  input  logic          write_i,
  output logic [3:0]    col_o,
  output logic [3:0]    row_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [1:0]    tap_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [3:0] LastCol = 4'(IMG_W - 2);
  localparam logic [3:0] LastRow = 4'(IMG_H - 2);

  logic [3:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [1:0]    tap_q, tap_d;
  logic          wrap_q, wrap_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          rd_en, wr_en;
  logic [31:0]   rd_addr;

  // A write strobe wins over a simultaneous read; the read is then not a tap read.
  assign wr_en = addr_cal_en_i && write_i;
  assign rd_en = addr_cal_en_i && read_i && !write_i;

  // tap[0] selects the right-hand column, tap[1] the lower row of the window.
  assign rd_addr = 32'(in_base_i)
                 + (32'(row_q) + 32'(tap_q[1])) * 32'(IMG_W)
                 + 32'(col_q) + 32'(tap_q[0]);

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    if (wr_en) begin
      mem_we_o   = 1'b1;
      mem_addr_o = out_base_i + out_cnt_q;
    end else if (rd_en) begin
      mem_addr_o = rd_addr[AW-1:0];
    end
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    tap_d     = tap_q;
    wrap_d    = wrap_q;
    out_cnt_d = out_cnt_q;
    done_d    = done_q;
    err_d     = err_q;

    if (wr_en) begin
      out_cnt_d = out_cnt_q + AW'(1);
      if (read_i) err_d = 1'b1;
    end

    if (pixel_cnt_en_i) begin
      tap_d  = 2'd0;
      wrap_d = 1'b0;
      if (done_q) begin
        err_d = 1'b1;
      end else if (col_q != LastCol) begin
        col_d = col_q + 4'd1;
      end else if (row_q != LastRow) begin
        col_d = 4'd0;
        row_d = row_q + 4'd1;
      end else begin
        done_d = 1'b1;
      end
    end else if (rd_en) begin
      // wrap_q marks that all four taps were already read for this origin.
      if (wrap_q) err_d = 1'b1;
      if (tap_q == 2'd3) wrap_d = 1'b1;
      tap_d = tap_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_clr_i) begin
      col_q     <= '0;
      row_q     <= '0;
      tap_q     <= '0;
      wrap_q    <= 1'b0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      tap_q     <= tap_d;
      wrap_q    <= wrap_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign tap_o  = tap_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Scoreboard bench for pixel_addr_gen: a window-index reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them.
module tb_pixel_addr_gen;

  localparam int unsigned IMG_W = 16;
  localparam int unsigned IMG_H = 16;
  localparam int unsigned AW    = 10;
  localparam int          NWin  = (IMG_W - 1) * (IMG_H - 1);

  logic          clk = 1'b0;
  logic          rst, frame_clr;
  logic [AW-1:0] in_base, out_base;
  logic          pixel_cnt_en, addr_cal_en, rd, wr;
  logic [3:0]    col, row;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    tap;
  logic          done, err;

  pixel_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_clr_i   (frame_clr),
    .in_base_i     (in_base),
    .out_base_i    (out_base),
    .pixel_cnt_en_i(pixel_cnt_en),
    .addr_cal_en_i (addr_cal_en),
    .read_i        (rd),
    .write_i       (wr),
    .col_o         (col),
    .row_o         (row),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .tap_o         (tap),
    .done_o        (done),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    col;
    logic [3:0]    row;
    logic [1:0]    tap;
    logic          done;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: window index, reads since last advance/clear, output count.
  int   m_win, m_rds, m_out;
  bit   m_done, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mem_addr", 32'(mem_addr), 32'(e.addr));
      check("mem_we", 32'(mem_we), 32'(e.we));
      check("col", 32'(col), 32'(e.col));
      check("row", 32'(row), 32'(e.row));
      check("tap", 32'(tap), 32'(e.tap));
      check("done", 32'(done), 32'(e.done));
      check("err", 32'(err), 32'(e.err));
    end
  end

  task automatic model_clear();
    m_win = 0; m_rds = 0; m_out = 0; m_done = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic cycle(input bit r, input bit clr, input bit pce, input bit ace,
                       input bit rdi, input bit wri);
    exp_t        e;
    int unsigned a;
    int          c, w;
    rst = r; frame_clr = clr; pixel_cnt_en = pce; addr_cal_en = ace; rd = rdi; wr = wri;
    c = m_win % (IMG_W - 1);
    w = m_win / (IMG_W - 1);
    e.col  = 4'(c);
    e.row  = 4'(w);
    e.tap  = 2'(m_rds % 4);
    e.done = m_done;
    e.err  = m_err;
    e.we   = 1'b0;
    e.addr = '0;
    if (ace && wri) begin
      e.we   = 1'b1;
      e.addr = AW'(int'(out_base) + m_out);
    end else if (ace && rdi) begin
      a = int'(in_base) + (w + (m_rds % 4) / 2) * IMG_W + c + (m_rds % 2);
      e.addr = AW'(a);
    end
    exp_q.push_back(e);

    if (r || clr) begin
      model_clear();
    end else begin
      if (ace && wri) begin
        m_out = (m_out + 1) % (1 << AW);
        if (rdi) m_err = 1;
      end
      if (pce) begin
        m_rds = 0;
        if (m_done) m_err = 1;
        else if (m_win == NWin - 1) m_done = 1;
        else m_win++;
      end else if (ace && rdi && !wri) begin
        if (m_rds >= 4) m_err = 1;
        m_rds++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 1, 0);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; frame_clr = 1'b0; pixel_cnt_en = 1'b0; addr_cal_en = 1'b0;
    rd = 1'b0; wr = 1'b0; in_base = 10'h040; out_base = 10'h200;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    cycle(1, 0, 0, 0, 0, 0);

    // Four taps of the first window, then tap wraps back to 0.
    reads(4);
    cycle(0, 0, 0, 0, 0, 0);

    // Row wrap from col 14,row 3 and first window of row 4.
    cycle(0, 1, 0, 0, 0, 0);
    advance(14 + 3 * (IMG_W - 1));
    cycle(0, 0, 1, 0, 0, 0);
    reads(4);

    // Fifth read, then read+write collision.
    cycle(0, 1, 0, 0, 0, 0);
    reads(5);
    cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 1, 0, 0);

    // Reset mid-window at col 5,row 2 after two reads.
    cycle(0, 1, 0, 0, 0, 0);
    advance(5 + 2 * (IMG_W - 1));
    reads(2);
    cycle(1, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Full frame of 4 reads, write and advance per window.
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < NWin; i++) begin
      reads(4);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    advance(1);
    cycle(0, 0, 0, 0, 0, 0);

    // Restart after done; first write goes to out_base again.
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Randomized traffic, including strobes without addr_cal_en and base changes.
    for (int i = 0; i < 3000; i++) begin
      bit r, clr, pce, ace, rdi, wri;
      if ($urandom_range(49) == 0) in_base = AW'($urandom);
      if ($urandom_range(49) == 0) out_base = AW'($urandom);
      r   = ($urandom_range(299) == 0);
      clr = ($urandom_range(199) == 0);
      pce = ($urandom_range(5) == 0);
      ace = ($urandom_range(3) != 0);
      rdi = ($urandom_range(1) == 0);
      wri = ($urandom_range(5) == 0);
      cycle(r, clr, pce, ace, rdi, wri);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_addr_gen.md
PIXEL_ADDR_GEN -- requirements
Module: pixel_addr_gen

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16, meaning input feature-map width in pixels (2..16).
REQ-002 The block SHALL have parameter IMG_H, default 16, meaning input feature-map height in pixels (2..16).
REQ-003 The block SHALL have parameter AW, default 10, meaning memory address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 frame_clr  input  1  synchronous restart of a new frame; clears counters, done and err.
REQ-007 in_base  input  AW  base address of the input feature map.
REQ-008 out_base  input  AW  base address of the output buffer.
REQ-009 pixel_cnt_en  input  1  advance window origin by one pixel.
REQ-010 addr_cal_en  input  1  address calculation enable.
REQ-011 read  input  1  memory read strobe from the controller.
REQ-012 write  input  1  memory write strobe from the controller.
REQ-013 col  output  4  current window-origin column.
REQ-014 row  output  4  current window-origin row.
REQ-015 mem_addr  output  AW  memory address for the current cycle.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 tap  output  2  index of the next window tap to be read.
REQ-018 done  output  1  sticky: last window origin has been passed.
REQ-019 err  output  1  sticky: protocol violation detected.

Function
REQ-020 Window origin SHALL scan raster order, col 0..IMG_W-2, row 0..IMG_H-2, covering every valid 2x2 window.
REQ-021 On pixel_cnt_en with col<IMG_W-2, col SHALL increment by 1 next cycle.
REQ-022 On pixel_cnt_en with col==IMG_W-2 and row<IMG_H-2, col SHALL become 0 and row SHALL increment.
REQ-023 On pixel_cnt_en at col==IMG_W-2, row==IMG_H-2, col/row SHALL hold and done SHALL set next cycle.
REQ-024 pixel_cnt_en while done=1 SHALL leave col/row unchanged and SHALL set err.
REQ-025 Tap order SHALL be 0:(row,col), 1:(row,col+1), 2:(row+1,col), 3:(row+1,col+1), matching load[3..0] of the controller.
REQ-026 When addr_cal_en=1 and read=1, mem_addr SHALL equal, combinationally, in_base + (row+dy)*IMG_W + (col+dx) for the current tap, modulo 2^AW.
REQ-027 Each cycle with addr_cal_en=1 and read=1, tap SHALL advance by 1 (3 wraps to 0).
REQ-028 A read when tap has already wrapped (fifth read since last pixel_cnt_en or frame_clr) SHALL set err; tap still advances.
REQ-029 pixel_cnt_en SHALL clear tap to 0 next cycle.
REQ-030 When addr_cal_en=1 and write=1, mem_addr SHALL equal out_base + out_cnt, mem_we SHALL be 1, and internal out_cnt (AW bits) SHALL increment next cycle.
REQ-031 mem_we SHALL be 0 in every other cycle; mem_addr SHALL be 0 when neither read nor write is qualified by addr_cal_en.
REQ-032 read and write both 1 with addr_cal_en=1 SHALL set err; write takes priority for mem_addr; tap SHALL NOT advance.
REQ-033 pixel_cnt_en coinciding with a qualified read SHALL give pixel_cnt_en priority: tap cleared, origin advanced.
REQ-034 read or write without addr_cal_en SHALL be ignored (no counter change, mem_we=0).
REQ-035 frame_clr SHALL clear col, row, tap, out_cnt, done, err next cycle and override all other inputs that cycle.
REQ-036 out_cnt SHALL wrap modulo 2^AW without flag.

Reset
REQ-037 rst SHALL override frame_clr and all inputs; next cycle col=0, row=0, tap=0, out_cnt=0, done=0, err=0, mem_we=0.
REQ-038 rst asserted mid-window (tap!=0) SHALL discard the partial window; no write issued after reset release until controller requests it.

Verification
REQ-039 rst, in_base=0x040, IMG_W=16, four qualified reads -> mem_addr 0x040, 0x041, 0x050, 0x051; tap returns to 0.
REQ-040 Origin col=14,row=3, pixel_cnt_en -> col=0,row=4; next reads start at in_base+64.
REQ-041 Full conv sequence (4 reads, write, pixel_cnt_en) x 225 windows with out_base=0x200 -> writes at 0x200..0x2E0, done=1 after the 225th pixel_cnt_en, err=0.
REQ-042 Fifth read without pixel_cnt_en -> err=1; read+write simultaneous -> err=1, mem_addr=out_base+out_cnt.
REQ-043 rst asserted after 2 reads at col=5,row=2 -> col=row=tap=0, err=0, mem_we=0 next cycle.
REQ-044 frame_clr after done=1 -> done=0, col=row=0, out_cnt=0; next write at out_base.
